// File: rtl/input_loader.sv
// rtl/input_loader.sv - converts a pixel stream to a fixed-point vector held for the first dense layer
// Optional feature macro: INPUT_LOADER_LAST_CHECK_EN (sample_last_i framing check, frame_error_o)
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif
`ifndef FRACTION_WIDTH
`define FRACTION_WIDTH 8
`endif

module input_loader #(
    parameter int NUM_INPUTS  = 16,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                                          clock_i,
    input  logic                                          reset_ni,
    input  logic                                          sample_valid_i,
    input  logic [PIXEL_WIDTH-1:0]                        sample_data_i,
    output logic                                          sample_ready_o,
    input  logic                                          network_done_i,
`ifdef INPUT_LOADER_LAST_CHECK_EN
    input  logic                                          sample_last_i,
    output logic                                          frame_error_o,
`endif
    output logic signed [`INTEGER_WIDTH-1:-`FRACTION_WIDTH] layer_inputs_o [NUM_INPUTS],
    output logic                                          layer_inputs_ready_o,
    output logic                                          busy_o
);

    localparam int IW   = `INTEGER_WIDTH;
    localparam int FW   = `FRACTION_WIDTH;
    localparam int IDXW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_INPUTS - 1);

    typedef enum logic {LOAD, HOLD} state_e;

    state_e                  state_q, state_d;
    logic [IDXW-1:0]         index_q, index_d;
    logic signed [IW-1:-FW]  inputs_q [NUM_INPUTS];
    logic signed [IW-1:-FW]  converted;
    logic                    transfer;
    logic                    at_last;
    logic                    frame_bad;

    // p / 2^PIXEL_WIDTH: the pixel sits just below the binary point, truncated if too wide
    generate
        if (FW >= PIXEL_WIDTH) begin : g_pad
            always_comb begin
                converted = '0;
                converted[-1 -: PIXEL_WIDTH] = sample_data_i;
            end
        end else begin : g_trunc
            always_comb begin
                converted = '0;
                converted[-1 -: FW] = sample_data_i[PIXEL_WIDTH-1 -: FW];
            end
        end
    endgenerate

    assign transfer = sample_valid_i && (state_q == LOAD);
    assign at_last  = (index_q == LAST_IDX);

`ifdef INPUT_LOADER_LAST_CHECK_EN
    assign frame_bad = (sample_last_i != at_last);
`else
    assign frame_bad = 1'b0;
`endif

    always_comb begin
        state_d              = state_q;
        index_d              = index_q;
        sample_ready_o       = 1'b0;
        layer_inputs_ready_o = 1'b0;
        busy_o               = 1'b0;
        case (state_q)
            LOAD: begin
                sample_ready_o = 1'b1;
                if (transfer) begin
                    if (frame_bad) begin
                        index_d = '0;
                    end else if (at_last) begin
                        index_d = '0;
                        state_d = HOLD;
                    end else begin
                        index_d = index_q + IDXW'(1);
                    end
                end
            end
            HOLD: begin
                layer_inputs_ready_o = 1'b1;
                busy_o               = 1'b1;
                if (network_done_i) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= LOAD;
            index_q <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) inputs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            if (transfer) inputs_q[index_q] <= converted;
        end
    end

`ifdef INPUT_LOADER_LAST_CHECK_EN
    logic frame_error_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni)     frame_error_q <= 1'b0;
        else if (transfer) frame_error_q <= frame_bad;
    end

    assign frame_error_o = frame_error_q;
`endif

    assign layer_inputs_o = inputs_q;

endmodule

// File: tb/tb_input_loader.sv
// tb/tb_input_loader.sv - table, directed and random checks of input_loader against a frame-level model
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif
`ifndef FRACTION_WIDTH
`define FRACTION_WIDTH 8
`endif

module tb_input_loader;
    localparam int N  = 16;
    localparam int PW = 8;
    localparam int IW = `INTEGER_WIDTH;
    localparam int FW = `FRACTION_WIDTH;
    localparam int W  = IW + FW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid = 1'b0;
    logic [PW-1:0] data = '0;
    logic done = 1'b0;
    logic last = 1'b0;
    logic rdy, lir, busy;
    logic signed [IW-1:-FW] li [N];
`ifdef INPUT_LOADER_LAST_CHECK_EN
    logic ferr;
`endif

    input_loader #(.NUM_INPUTS(N), .PIXEL_WIDTH(PW)) dut (
        .clock_i              (clk),
        .reset_ni             (rst_n),
        .sample_valid_i       (valid),
        .sample_data_i        (data),
        .sample_ready_o       (rdy),
        .network_done_i       (done),
`ifdef INPUT_LOADER_LAST_CHECK_EN
        .sample_last_i        (last),
        .frame_error_o        (ferr),
`endif
        .layer_inputs_o       (li),
        .layer_inputs_ready_o (lir),
        .busy_o               (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Frame-level reference: how many samples of the current frame were taken,
    // whether a finished frame is being presented, and the value of each slot.
    bit           m_hold;
    int           m_cnt;
    logic [W-1:0] m_vec [N];
    bit           m_err;

    typedef struct {
        bit v;
        int p;
        bit d;
        bit l;
        bit e_rdy;
        bit e_lir;
        bit e_busy;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] conv(input int p);
        longint r;
        r = (longint'(p) * (longint'(1) << FW)) / (longint'(1) << PW);
        return W'(r);
    endfunction

    task automatic model_reset();
        m_hold = 0;
        m_cnt  = 0;
        m_err  = 0;
        for (int k = 0; k < N; k++) m_vec[k] = '0;
    endtask

    task automatic model_edge(input bit v, input int p, input bit d, input bit l);
        bit final_s;
        bit bad;
        if (!m_hold) begin
            if (v) begin
                final_s = (m_cnt == N - 1);
                bad = 0;
                m_vec[m_cnt] = conv(p);
`ifdef INPUT_LOADER_LAST_CHECK_EN
                bad   = (l != final_s);
                m_err = bad;
`endif
                if (bad) m_cnt = 0;
                else if (final_s) begin
                    m_cnt  = 0;
                    m_hold = 1;
                end else m_cnt++;
            end
        end else if (d) begin
            m_hold = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] a;
        chk({tag, "_sample_ready"}, rdy, !m_hold);
        chk({tag, "_inputs_ready"}, lir, m_hold);
        chk({tag, "_busy"}, busy, m_hold);
        for (int k = 0; k < N; k++) begin
            a = li[k];
            chk($sformatf("%s_elem%0d", tag, k), a, m_vec[k]);
        end
`ifdef INPUT_LOADER_LAST_CHECK_EN
        chk({tag, "_frame_error"}, ferr, m_err);
`endif
    endtask

    task automatic step(input string tag, input bit v, input int p, input bit d, input bit l);
        valid = v;
        data  = PW'(p);
        done  = d;
        last  = l;
        @(posedge clk);
        model_edge(v, p, d, l);
        #1;
        check_all(tag);
    endtask

    initial begin
        vec_t r;
        bit   vv;
        bit   ll;
        bit   dd;

        // reset state
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // first frame p=0..15, then a blocked sample during HOLD, then completion
        for (int k = 0; k < N; k++) begin
            r = '{v:1, p:k, d:0, l:(k == N-1), e_rdy:(k != N-1), e_lir:(k == N-1), e_busy:(k == N-1)};
            tbl.push_back(r);
        end
        for (int k = 0; k < 20; k++) begin
            r = '{v:1, p:255, d:0, l:0, e_rdy:0, e_lir:1, e_busy:1};
            tbl.push_back(r);
        end
        r = '{v:1, p:255, d:1, l:0, e_rdy:1, e_lir:0, e_busy:0};
        tbl.push_back(r);
        r = '{v:1, p:255, d:0, l:0, e_rdy:1, e_lir:0, e_busy:0};
        tbl.push_back(r);

        foreach (tbl[i]) begin
            step("tbl", tbl[i].v, tbl[i].p, tbl[i].d, tbl[i].l);
            chk($sformatf("tbl%0d_rdy", i), rdy, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_lir", i), lir, tbl[i].e_lir);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
        end
        chk("held_p255_raw", W'(li[0]), conv(255));
        chk("prev_frame_elem7_raw", W'(li[7]), conv(7));

        // reset mid-frame after 7 transfers of this frame
        for (int k = 0; k < 6; k++) step("pre_rst", 1, 100 + k, 0, 0);
        valid = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_rst");
        chk("mid_rst_elem0_zero", W'(li[0]), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < N; k++) step("fresh", 1, $urandom_range(0, 255), 0, k == N-1);
        chk("fresh_hold", lir, 1);
        step("fresh_done", 0, 0, 1, 0);

        // network_done held high through LOAD; valid every other cycle
        for (int i = 0; i < 2 * N; i++) begin
            vv = (i % 2 == 0);
            ll = vv && (m_cnt == N - 1);
            step("done_held", vv, $urandom_range(0, 255), 1, ll);
            if (i == 2 * N - 2) chk("done_held_enter_hold", lir, 1);
            if (i == 2 * N - 1) chk("done_held_exit", lir, 0);
        end

`ifdef INPUT_LOADER_LAST_CHECK_EN
        for (int k = 0; k < 5; k++) step("early_last", 1, 50 + k, 0, k == 4);
        chk("early_last_err", ferr, 1);
        chk("early_last_lir", lir, 0);
        for (int k = 0; k < N; k++) begin
            step("good_frame", 1, 10 + k, 0, k == N-1);
            if (k == 0) chk("err_cleared", ferr, 0);
        end
        chk("good_frame_lir", lir, 1);
        step("good_done", 0, 0, 1, 0);
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            vv = ($urandom_range(0, 3) != 0);
            dd = ($urandom_range(0, 4) == 0);
            ll = (m_cnt == N - 1);
`ifdef INPUT_LOADER_LAST_CHECK_EN
            if ($urandom_range(0, 19) == 0) ll = !ll;
`endif
            step("rand", vv, $urandom_range(0, 255), dd, ll);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
